// File: rtl/cp0_regfile_if.sv
// CP0 register-file types and the commit-stage bus between the exception handler and CP0.
package cp0_regfile_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned EXC_CODE_W = 5;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned EXT_INT_W  = 6;

  localparam logic [REG_ADDR_W-1:0] REG_BADVADDR = 5'd8;
  localparam logic [REG_ADDR_W-1:0] REG_COUNT    = 5'd9;
  localparam logic [REG_ADDR_W-1:0] REG_COMPARE  = 5'd11;
  localparam logic [REG_ADDR_W-1:0] REG_STATUS   = 5'd12;
  localparam logic [REG_ADDR_W-1:0] REG_CAUSE    = 5'd13;
  localparam logic [REG_ADDR_W-1:0] REG_EPC      = 5'd14;

  typedef enum logic [3:0] {
    OP_NONE    = 4'd0,
    OP_EXC     = 4'd1,
    OP_BADVA   = 4'd2,
    OP_ERET    = 4'd3,
    OP_MTC0    = 4'd4,
    OP_TLB_EXC = 4'd5,
    OP_TLBW    = 4'd6,
    OP_TLBR    = 4'd7,
    OP_TLBP    = 4'd8
  } cp0_op_t;

  typedef struct packed {
    logic [XLEN-1:0]       epc;
    logic                  cause_bd;
    logic [EXC_CODE_W-1:0] cause_exccode;
    logic [XLEN-1:0]       badvaddr;
  } exc_info_t;
endpackage

interface cp0_regfile_if;
  import cp0_regfile_pkg::*;

  cp0_op_t               cp0_op;
  exc_info_t             exc_info;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_data;
  logic [XLEN-1:0]       cp0_epc;
  logic [XLEN-1:0]       cp0_status;
  logic [XLEN-1:0]       cp0_cause;

  modport master (
    output cp0_op, exc_info, wr_addr, wr_data, rd_addr,
    input  rd_data, cp0_epc, cp0_status, cp0_cause
  );

  modport slave (
    input  cp0_op, exc_info, wr_addr, wr_data, rd_addr,
    output rd_data, cp0_epc, cp0_status, cp0_cause
  );
endinterface

// File: rtl/cp0_regfile.sv
// MIPS-style CP0 subset: BadVAddr, Count, Compare, Status, Cause, EPC.
// Define CP0_TIMER_INT_EN to enable the Count/Compare timer interrupt (Cause.TI -> IP[7]).
module cp0_regfile
  import cp0_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXT_INT_W-1:0] ext_int,
  cp0_regfile_if.slave         bus
);

  logic [XLEN-1:0]       badvaddr_q, badvaddr_d;
  logic [XLEN-1:0]       count_q, count_d;
  logic [XLEN-1:0]       compare_q, compare_d;
  logic [XLEN-1:0]       epc_q, epc_d;
  logic [7:0]            im_q, im_d;
  logic                  exl_q, exl_d;
  logic                  ie_q, ie_d;
  logic                  bd_q, bd_d;
  logic [EXC_CODE_W-1:0] exccode_q, exccode_d;
  logic [1:0]            ip_sw_q, ip_sw_d;
  logic [4:0]            ip_hw_q, ip_hw_d;
  logic                  ip7_q, ip7_d;
  logic                  ti_q, ti_d;
  logic                  tick_q, tick_d;
  logic                  is_exc;
  logic                  is_mtc0;
  logic [XLEN-1:0]       status_val;
  logic [XLEN-1:0]       cause_val;

  assign is_exc  = (bus.cp0_op == OP_EXC) || (bus.cp0_op == OP_BADVA) ||
                   (bus.cp0_op == OP_TLB_EXC);
  assign is_mtc0 = (bus.cp0_op == OP_MTC0);

`ifdef CP0_TIMER_INT_EN
  logic wr_compare;
  assign wr_compare = is_mtc0 && (bus.wr_addr == REG_COMPARE);

  // Compare match latches TI; a Compare write clears it and beats a same-cycle match.
  always_comb begin
    ti_d = ti_q;
    if ((count_q == compare_q) && (count_q != '0)) ti_d = 1'b1;
    if (wr_compare) ti_d = 1'b0;
  end
`else
  assign ti_d = 1'b0;
`endif

  // Next-state for all architectural registers.
  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = ext_int[4:0];
    ip7_d      = ext_int[5] | ti_d;
    tick_d     = ~tick_q;

    if (tick_q) count_d = count_q + XLEN'(1);

    if (is_exc) begin
      exccode_d = bus.exc_info.cause_exccode;
      epc_d     = bus.exc_info.epc;
      bd_d      = bus.exc_info.cause_bd;
      exl_d     = 1'b1;
    end
    if (bus.cp0_op == OP_BADVA) badvaddr_d = bus.exc_info.badvaddr;
    if (bus.cp0_op == OP_ERET) exl_d = 1'b0;

    // Software write; a Count load overrides the increment but leaves the tick phase running.
    if (is_mtc0) begin
      case (bus.wr_addr)
        REG_COUNT:   count_d   = bus.wr_data;
        REG_COMPARE: compare_d = bus.wr_data;
        REG_STATUS: begin
          im_d  = bus.wr_data[15:8];
          exl_d = bus.wr_data[1];
          ie_d  = bus.wr_data[0];
        end
        REG_CAUSE:   ip_sw_d   = bus.wr_data[9:8];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      ip7_q      <= 1'b0;
      ti_q       <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      ip7_q      <= ip7_d;
      ti_q       <= ti_d;
      tick_q     <= tick_d;
    end
  end

  assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_val  = {bd_q, ti_q, 14'b0, ip7_q, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};

  assign bus.cp0_epc    = epc_q;
  assign bus.cp0_status = status_val;
  assign bus.cp0_cause  = cause_val;

  // MFC0 read port, no bypass of same-cycle updates.
  always_comb begin
    case (bus.rd_addr)
      REG_BADVADDR: bus.rd_data = badvaddr_q;
      REG_COUNT:    bus.rd_data = count_q;
      REG_COMPARE:  bus.rd_data = compare_q;
      REG_STATUS:   bus.rd_data = status_val;
      REG_CAUSE:    bus.rd_data = cause_val;
      REG_EPC:      bus.rd_data = epc_q;
      default:      bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Randomized self-checking bench for cp0_regfile against a register-image reference model.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ext_int;

  cp0_regfile_if bus ();

  cp0_regfile dut (
    .clk     (clk),
    .rst     (rst),
    .ext_int (ext_int),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] m_badva, m_count, m_compare, m_status, m_cause, m_epc;
  int unsigned m_cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_badva   = 32'h0;
    m_count   = 32'h0;
    m_compare = 32'h0;
    m_status  = 32'h0040_0000;
    m_cause   = 32'h0;
    m_epc     = 32'h0;
    m_cycles  = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    case (ra)
      5'd8:    return m_badva;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic peek(input logic [4:0] ra, output logic [31:0] v);
    bus.rd_addr = ra;
    #1;
    v = bus.rd_data;
  endtask

  // One commit cycle: drive, check pre-update outputs, advance model across the edge.
  task automatic step(input logic r, input cp0_op_t op, input exc_info_t info,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [5:0] ei);
    logic [31:0] n_badva, n_count, n_compare, n_status, n_cause, n_epc;
    logic        tin;
    logic        exc;
    rst          = r;
    bus.cp0_op   = op;
    bus.exc_info = info;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.rd_addr  = ra;
    ext_int      = ei;
    #2;
    check($sformatf("rd_data[%0d]", ra), bus.rd_data, model_read(ra));
    check("cp0_status", bus.cp0_status, m_status);
    check("cp0_cause", bus.cp0_cause, m_cause);
    check("cp0_epc", bus.cp0_epc, m_epc);

    n_badva   = m_badva;
    n_count   = m_count;
    n_compare = m_compare;
    n_status  = m_status;
    n_cause   = m_cause;
    n_epc     = m_epc;
    if (m_cycles % 2 == 1) n_count = m_count + 32'd1;
    n_cause[14:10] = ei[4:0];
    exc = (op == OP_EXC) || (op == OP_BADVA) || (op == OP_TLB_EXC);
    if (exc) begin
      n_cause[31]  = info.cause_bd;
      n_cause[6:2] = info.cause_exccode;
      n_epc        = info.epc;
      n_status[1]  = 1'b1;
    end
    if (op == OP_BADVA) n_badva = info.badvaddr;
    if (op == OP_ERET) n_status[1] = 1'b0;
    if (op == OP_MTC0) begin
      case (wa)
        5'd9:    n_count = wd;
        5'd11:   n_compare = wd;
        5'd12:   n_status = 32'h0040_0000 | (wd & 32'h0000_FF03);
        5'd13:   n_cause[9:8] = wd[9:8];
        default: ;
      endcase
    end
`ifdef CP0_TIMER_INT_EN
    tin = m_cause[30] | ((m_count == m_compare) && (m_count != 32'h0));
    if (op == OP_MTC0 && wa == 5'd11) tin = 1'b0;
`else
    tin = 1'b0;
`endif
    n_cause[30] = tin;
    n_cause[15] = ei[5] | tin;

    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else begin
      m_badva   = n_badva;
      m_count   = n_count;
      m_compare = n_compare;
      m_status  = n_status;
      m_cause   = n_cause;
      m_epc     = n_epc;
      m_cycles  = m_cycles + 1;
    end
  endtask

  logic [4:0] addrs [8];
  exc_info_t  no_info;
  exc_info_t  rinfo;
  logic [31:0] v;
  logic [31:0] rwd;
  cp0_op_t     rop;
  logic        hit;

  initial begin
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
    no_info = '0;
    rst = 1'b1;
    bus.cp0_op = OP_NONE;
    bus.exc_info = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    ext_int = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    #1;
    check("reset_status", bus.cp0_status, 32'h0040_0000);
    check("reset_cause", bus.cp0_cause, 32'h0);
    check("reset_epc", bus.cp0_epc, 32'h0);

    repeat (10) step(1'b0, OP_NONE, no_info, 5'd0, 32'h0, 5'd9, 6'h0);
    peek(5'd9, v);
    check("count_after_10", v, 32'd5);
    check("idle_status", bus.cp0_status, 32'h0040_0000);
    check("idle_cause", bus.cp0_cause, 32'h0);

    step(1'b0, OP_EXC, '{epc: 32'hBFC0_0100, cause_bd: 1'b1, cause_exccode: 5'h08,
                         badvaddr: 32'h0}, 5'd0, 32'h0, 5'd14, 6'h0);
    check("exc_epc", bus.cp0_epc, 32'hBFC0_0100);
    check("exc_cause", bus.cp0_cause, 32'h8000_0020);
    check("exc_exl", 32'(bus.cp0_status[1]), 32'd1);
    step(1'b0, OP_ERET, no_info, 5'd0, 32'h0, 5'd12, 6'h0);
    check("eret_status", bus.cp0_status, 32'h0040_0000);

    step(1'b0, OP_BADVA, '{epc: 32'h8000_1000, cause_bd: 1'b0, cause_exccode: 5'h04,
                           badvaddr: 32'h0000_0003}, 5'd0, 32'h0, 5'd8, 6'h0);
    peek(5'd8, v);
    check("badva_value", v, 32'h0000_0003);
    check("badva_exccode", 32'(bus.cp0_cause[6:2]), 32'h04);

    step(1'b0, OP_NONE, no_info, 5'd0, 32'h0, 5'd13, 6'b000001);
    check("ext_int_ip2", 32'(bus.cp0_cause[10]), 32'd1);
    step(1'b0, OP_NONE, no_info, 5'd0, 32'h0, 5'd13, 6'h0);
    step(1'b0, OP_MTC0, no_info, 5'd13, 32'hFFFF_FFFF, 5'd13, 6'h0);
    check("mtc0_cause", bus.cp0_cause, 32'h0000_0310);
    step(1'b0, OP_MTC0, no_info, 5'd12, 32'hFFFF_FFFF, 5'd12, 6'h0);
    check("mtc0_status", bus.cp0_status, 32'h0040_FF03);
    step(1'b0, OP_MTC0, no_info, 5'd12, 32'h0, 5'd12, 6'h0);
    step(1'b0, OP_MTC0, no_info, 5'd13, 32'h0, 5'd13, 6'h0);

    step(1'b0, OP_MTC0, no_info, 5'd9, 32'h0, 5'd9, 6'h0);
    step(1'b0, OP_MTC0, no_info, 5'd11, 32'd4, 5'd11, 6'h0);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step(1'b0, OP_NONE, no_info, 5'd0, 32'h0, 5'd9, 6'h0);
      hit = bus.cp0_cause[30];
    end
`ifdef CP0_TIMER_INT_EN
    check("timer_ti", 32'(bus.cp0_cause[30]), 32'd1);
    check("timer_ip7", 32'(bus.cp0_cause[15]), 32'd1);
    peek(5'd9, v);
    check("timer_count_hit", 32'((v == 32'd4) || (v == 32'd5)), 32'd1);
    step(1'b0, OP_MTC0, no_info, 5'd11, 32'd100, 5'd13, 6'h0);
    check("compare_clears_ti", 32'(bus.cp0_cause[30]), 32'd0);
    check("compare_clears_ip7", 32'(bus.cp0_cause[15]), 32'd0);
`else
    check("timer_ti_off", 32'(bus.cp0_cause[30]), 32'd0);
    check("timer_ip7_off", 32'(bus.cp0_cause[15]), 32'd0);
`endif

    step(1'b1, OP_MTC0, no_info, 5'd12, 32'hFFFF_FFFF, 5'd12, 6'h0);
    check("midrst_status", bus.cp0_status, 32'h0040_0000);
    peek(5'd9, v);
    check("midrst_count", v, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rop = cp0_op_t'(4'($urandom_range(0, 8)));
      rinfo.epc = $urandom;
      rinfo.cause_bd = 1'($urandom_range(0, 1));
      rinfo.cause_exccode = 5'($urandom_range(0, 31));
      rinfo.badvaddr = $urandom;
      rwd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      step(1'($urandom_range(0, 63) == 0), rop, rinfo, addrs[$urandom_range(0, 7)], rwd,
           addrs[$urandom_range(0, 7)], 6'($urandom_range(0, 63)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
CP0_REGFILE -- requirements
Module: cp0_regfile

Interface
REQ-001 Parameters: none; all register layouts are fixed by this document.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 cp0_op  in  cp0_op_t  commit-stage CP0 action (OP_NONE/EXC/BADVA/ERET/MTC0/TLB*) from the exception handler.
REQ-005 exc_info  in  exc_info_t  {epc, cause_bd, cause_exccode[4:0], badvaddr} from the exception handler.
REQ-006 wr_addr  in  5  MTC0 destination register number (sel fixed 0).
REQ-007 wr_data  in  32  MTC0 write data.
REQ-008 rd_addr  in  5  MFC0 source register number.
REQ-009 rd_data  out  32  MFC0 read data, combinational from current register state.
REQ-010 ext_int  in  6  hardware interrupt lines, active-high, level.
REQ-011 cp0_epc / cp0_status / cp0_cause  out  32 each  current register values fed back to the exception handler.

Function
REQ-012 Registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); rd_data for any other rd_addr SHALL be 0.
REQ-013 Status layout: BEV[22], IM[15:8], EXL[1], IE[0]; all other bits read 0; MTC0 writes only IM, EXL, IE; BEV is read-only 1.
REQ-014 Cause layout: BD[31], TI[30], IP[15:8], ExcCode[6:2]; all other bits read 0; MTC0 writes only IP[9:8].
REQ-015 Cause.IP[14:10] SHALL register ext_int[4:0] every cycle (one-cycle latency); IP[15] = ext_int[5] OR TI, registered.
REQ-016 Count SHALL increment by 1 every second cycle using an internal toggle bit cleared on reset; wrap 0xFFFFFFFF -> 0.
REQ-017 TI SHALL set on the cycle after Count == Compare (Count != 0 after reset); it stays set until an MTC0 to Compare, which clears TI in the same update.
REQ-018 TI set and MTC0-Compare in the same cycle: the clear wins.
REQ-019 MTC0 to Count SHALL load wr_data and take priority over the increment that cycle; the toggle bit is not reset.
REQ-020 OP_EXC: Cause.ExcCode <= exc_info.cause_exccode, EPC <= exc_info.epc, Cause.BD <= exc_info.cause_bd, Status.EXL <= 1; the handler already supplies the old EPC/BD when EXL was 1.
REQ-021 OP_BADVA: OP_EXC actions plus BadVAddr <= exc_info.badvaddr.
REQ-022 OP_ERET: Status.EXL <= 0; no other register changes.
REQ-023 OP_MTC0: write register wr_addr per REQ-013/014/016-019; a write to BadVAddr or an unimplemented number is ignored.
REQ-024 OP_TLB_EXC, OP_TLBW, OP_TLBR, OP_TLBP and OP_NONE: no change to the six registers (TLB state is handled elsewhere); OP_TLB_EXC SHALL still apply OP_EXC actions.
REQ-025 Every update takes effect at the next posedge; rd_data and cp0_* outputs show pre-update values in the commit cycle (no bypass).
REQ-026 Timer and ext_int updates to Cause.IP SHALL coexist with an OP_EXC write of ExcCode/BD in the same cycle.

Reset
REQ-027 On rst: Status = 0x00400000; Cause, EPC, BadVAddr, Count, Compare, and the toggle bit = 0; rd_data follows the reset state.
REQ-028 rst asserted mid-operation overrides any cp0_op or MTC0 in that cycle.

Configuration
REQ-029 Macro CP0_TIMER_INT_EN: when defined, REQ-017/018 are active and TI feeds IP[15].
REQ-030 Without the macro: TI reads 0, IP[15] = registered ext_int[5], and Count/Compare remain readable and writable.

Verification
REQ-031 rst, then idle 10 cycles -> Status 0x00400000, Cause 0, Count 5.
REQ-032 OP_EXC with epc 0xBFC00100, bd 1, exccode 0x08 -> next cycle EPC 0xBFC00100, Cause 0x80000020, Status.EXL 1; then OP_ERET -> EXL 0.
REQ-033 OP_BADVA with badvaddr 0x00000003, exccode 0x04 -> BadVAddr 0x00000003, Cause.ExcCode 0x04.
REQ-034 MTC0 Compare = 4, run -> TI and IP[15] set once Count reaches 4; MTC0 Compare = 100 -> TI 0 on the next cycle (with CP0_TIMER_INT_EN defined); without the macro, TI stays 0.
REQ-035 ext_int = 6'b000001 -> Cause[10] = 1 one cycle later; MTC0 Cause 0xFFFFFFFF -> only IP[9:8] change; MTC0 Status 0xFFFFFFFF -> Status 0x0040FF03.
